pipeline_stage_controller: RTL and testbench

PIPELINE_STAGE_CONTROLLER -- requirements
Module: pipeline_stage_controller

---
 rtl/pipeline_stage_controller_pkg.sv | 13 +
 rtl/pipeline_stage_controller_hazard_detect.sv | 31 +++
 rtl/pipeline_stage_controller.sv | 132 +++++++++++++
 tb/tb_pipeline_stage_controller.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stage_controller_pkg.sv
// Shared types for the pipeline stage controller: FSM state encoding and register-index width.
package pipeline_stage_controller_pkg;

   localparam int REG_IDX_W = 4;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_MEM_WAIT  = 2'd1,
      ST_BR_SHADOW = 2'd2,
      ST_RSVD      = 2'd3
   } state_e;

endpackage

// File: rtl/pipeline_stage_controller_hazard_detect.sv
// Purely combinational RAW hazard detector comparing ID sources against EXE/MEM destinations.
module hazard_detect
   import pipeline_stage_controller_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_src1,
   input  logic [REG_IDX_W-1:0] id_src2,
   input  logic                 id_two_src,
   input  logic                 id_ignore_hazard,
   input  logic [REG_IDX_W-1:0] exe_dest,
   input  logic                 exe_wb_en,
   input  logic                 exe_mem_read,
   input  logic [REG_IDX_W-1:0] mem_dest,
   input  logic                 mem_wb_en,
   input  logic                 fwd_en,
   output logic                 raw_hazard
);

   logic exe_match;
   logic mem_match;

   always_comb begin
      exe_match  = exe_wb_en & ((id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest)));
      mem_match  = mem_wb_en & ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));
      // With forwarding, only a load in EXE cannot be bypassed in time.
      raw_hazard = fwd_en ? (exe_match & exe_mem_read) : (exe_match | mem_match);
      if (id_ignore_hazard) begin
         raw_hazard = 1'b0;
      end
   end

endmodule

// File: rtl/pipeline_stage_controller.sv
// Pipeline stall/flush controller: data-hazard bubbles, branch flush shadow, memory-wait freeze,
// with a saturating stall counter and a sticky memory-timeout flag.
module pipeline_stage_controller
   import pipeline_stage_controller_pkg::*;
#(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] id_src1,
   input  logic [REG_IDX_W-1:0] id_src2,
   input  logic                 id_two_src,
   input  logic                 id_ignore_hazard,
   input  logic [REG_IDX_W-1:0] exe_dest,
   input  logic                 exe_wb_en,
   input  logic                 exe_mem_read,
   input  logic [REG_IDX_W-1:0] mem_dest,
   input  logic                 mem_wb_en,
   input  logic                 fwd_en,
   input  logic                 branch_taken,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   output logic                 hazard,
   output logic                 freeze_if,
   output logic                 freeze_pipe,
   output logic                 flush,
   output logic [1:0]           state,
   output logic [CNT_W-1:0]     stall_count,
   output logic                 mem_timeout
);

   localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
   localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(WAIT_LIMIT);

   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              timeout_q, timeout_d;

   logic raw_hazard;
   logic freeze_pipe_c;
   logic flush_c;
   logic hazard_c;
   logic freeze_if_c;

   hazard_detect u_hazard_detect (
      .id_src1          (id_src1),
      .id_src2          (id_src2),
      .id_two_src       (id_two_src),
      .id_ignore_hazard (id_ignore_hazard),
      .exe_dest         (exe_dest),
      .exe_wb_en        (exe_wb_en),
      .exe_mem_read     (exe_mem_read),
      .mem_dest         (mem_dest),
      .mem_wb_en        (mem_wb_en),
      .fwd_en           (fwd_en),
      .raw_hazard       (raw_hazard)
   );

   always_comb begin
      freeze_pipe_c = mem_req & ~mem_ready;
      flush_c       = branch_taken & ~freeze_pipe_c;
      hazard_c      = raw_hazard & ~freeze_pipe_c & ~flush_c & (state_q != ST_BR_SHADOW);
      freeze_if_c   = hazard_c | freeze_pipe_c;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN, ST_BR_SHADOW: begin
            if (freeze_pipe_c) begin
               state_d = ST_MEM_WAIT;
            end else if (flush_c) begin
               state_d = ST_BR_SHADOW;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            // A branch held off by the wait is taken on the release cycle.
            if (!freeze_pipe_c) begin
               state_d = branch_taken ? ST_BR_SHADOW : ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      stall_cnt_d = stall_cnt_q;
      if (state_q == ST_MEM_WAIT) begin
         if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
         if ((wait_cnt_d == WAIT_MAX) && !mem_ready) begin
            timeout_d = 1'b1;
         end
      end else if (state_d == ST_MEM_WAIT) begin
         wait_cnt_d = '0;
      end
      if (freeze_if_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   // Reset holds every observable output at its idle value, even before the first edge.
   assign hazard      = hazard_c & ~rst;
   assign freeze_if   = freeze_if_c & ~rst;
   assign freeze_pipe = freeze_pipe_c & ~rst;
   assign flush       = flush_c & ~rst;
   assign state       = rst ? ST_RUN : state_q;
   assign stall_count = rst ? '0 : stall_cnt_q;
   assign mem_timeout = timeout_q & ~rst;

endmodule

// File: tb/tb_pipeline_stage_controller.sv
// Bench for pipeline_stage_controller: vector table, directed multi-cycle sequences, random vs model.
module tb_pipeline_stage_controller;

   localparam int WAIT_LIMIT = 3;
   localparam int CNT_W      = 5;
   localparam int STALL_MAX  = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic [3:0]       id_src1, id_src2, exe_dest, mem_dest;
   logic             id_two_src, id_ignore_hazard, exe_wb_en, exe_mem_read, mem_wb_en;
   logic             fwd_en, branch_taken, mem_req, mem_ready;
   logic             hazard, freeze_if, freeze_pipe, flush, mem_timeout;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_count;

   int tests = 0;
   int fails = 0;

   pipeline_stage_controller #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .id_src1          (id_src1),
      .id_src2          (id_src2),
      .id_two_src       (id_two_src),
      .id_ignore_hazard (id_ignore_hazard),
      .exe_dest         (exe_dest),
      .exe_wb_en        (exe_wb_en),
      .exe_mem_read     (exe_mem_read),
      .mem_dest         (mem_dest),
      .mem_wb_en        (mem_wb_en),
      .fwd_en           (fwd_en),
      .branch_taken     (branch_taken),
      .mem_req          (mem_req),
      .mem_ready        (mem_ready),
      .hazard           (hazard),
      .freeze_if        (freeze_if),
      .freeze_pipe      (freeze_pipe),
      .flush            (flush),
      .state            (state),
      .stall_count      (stall_count),
      .mem_timeout      (mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       fwd, two, ign, mrd, ewb, mwb;
      logic [3:0] s1, s2, ed, md;
      logic       br, mreq, mrdy;
      logic       e_hz, e_fl, e_fp, e_fi;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
      id_two_src = 1'b0; id_ignore_hazard = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
      mem_wb_en = 1'b0; fwd_en = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic set_exe_hazard();
      fwd_en = 1'b0; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
   endtask

   // Reference hazard rule: a stage counts if forwarding cannot cover it.
   function automatic bit ref_raw();
      bit         hit = 0;
      logic [3:0] dst[2];
      bit         wb[2];
      bit         counts[2];
      dst[0] = exe_dest; wb[0] = exe_wb_en; counts[0] = !fwd_en || exe_mem_read;
      dst[1] = mem_dest; wb[1] = mem_wb_en; counts[1] = !fwd_en;
      for (int s = 0; s < 2; s++) begin
         if (counts[s] && wb[s] && (id_src1 == dst[s] || (id_two_src && id_src2 == dst[s])))
            hit = 1;
      end
      return hit && !id_ignore_hazard;
   endfunction

   initial begin
      int m_state, m_wait, m_stall, nxt;
      bit m_to, e_fp, e_fl, e_hz, e_fi;

      //            fwd two ign mrd ewb mwb s1    s2    ed    md    br mreq mrdy hz fl fp fi
      vecs[0]  = '{0, 0, 0, 0, 1, 0, 4'd3, 4'd0, 4'd3, 4'd0, 0, 0, 0, 1, 0, 0, 1};
      vecs[1]  = '{1, 1, 0, 1, 1, 0, 4'd0, 4'd5, 4'd5, 4'd0, 0, 0, 0, 1, 0, 0, 1};
      vecs[2]  = '{1, 1, 0, 0, 1, 0, 4'd0, 4'd5, 4'd5, 4'd0, 0, 0, 0, 0, 0, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 1, 1, 4'd7, 4'd0, 4'd2, 4'd7, 0, 0, 0, 1, 0, 0, 1};
      vecs[4]  = '{1, 0, 0, 1, 1, 1, 4'd7, 4'd0, 4'd2, 4'd7, 0, 0, 0, 0, 0, 0, 0};
      vecs[5]  = '{0, 0, 0, 0, 1, 0, 4'd1, 4'd4, 4'd4, 4'd0, 0, 0, 0, 0, 0, 0, 0};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 4'd3, 4'd0, 4'd3, 4'd0, 0, 0, 0, 0, 0, 0, 0};
      vecs[7]  = '{0, 0, 1, 0, 1, 0, 4'd3, 4'd0, 4'd3, 4'd0, 0, 0, 0, 0, 0, 0, 0};
      vecs[8]  = '{0, 0, 0, 0, 1, 0, 4'd3, 4'd0, 4'd3, 4'd0, 0, 1, 0, 0, 0, 1, 1};
      vecs[9]  = '{0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd9, 4'd9, 1, 1, 0, 0, 0, 1, 1};
      vecs[10] = '{0, 0, 0, 0, 1, 0, 4'd3, 4'd0, 4'd3, 4'd0, 1, 0, 0, 0, 1, 0, 0};
      vecs[11] = '{0, 0, 0, 0, 1, 0, 4'd3, 4'd0, 4'd3, 4'd0, 0, 1, 1, 1, 0, 0, 1};

      // Reset state, with hazard-causing inputs applied during reset.
      rst = 1'b1;
      idle();
      set_exe_hazard();
      mem_req = 1'b1;
      branch_taken = 1'b1;
      cyc();
      #2;
      check("rst_state", state, 0);
      check("rst_stall", stall_count, 0);
      check("rst_timeout", mem_timeout, 0);
      check("rst_hazard", hazard, 0);
      check("rst_freeze_if", freeze_if, 0);
      check("rst_freeze_pipe", freeze_pipe, 0);
      check("rst_flush", flush, 0);
      rst = 1'b0;
      idle();
      cyc();

      foreach (vecs[i]) begin
         do_reset();
         fwd_en = vecs[i].fwd; id_two_src = vecs[i].two; id_ignore_hazard = vecs[i].ign;
         exe_mem_read = vecs[i].mrd; exe_wb_en = vecs[i].ewb; mem_wb_en = vecs[i].mwb;
         id_src1 = vecs[i].s1; id_src2 = vecs[i].s2; exe_dest = vecs[i].ed; mem_dest = vecs[i].md;
         branch_taken = vecs[i].br; mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
         #2;
         check($sformatf("vec%0d_hazard", i), hazard, vecs[i].e_hz);
         check($sformatf("vec%0d_flush", i), flush, vecs[i].e_fl);
         check($sformatf("vec%0d_freeze_pipe", i), freeze_pipe, vecs[i].e_fp);
         check($sformatf("vec%0d_freeze_if", i), freeze_if, vecs[i].e_fi);
         cyc();
      end

      // Hazard stalls IF in the same cycle and the stall counter steps 0 -> 1.
      do_reset();
      set_exe_hazard();
      #2;
      check("stall_hz_now", hazard, 1);
      check("stall_cnt0", stall_count, 0);
      cyc();
      idle();
      #2;
      check("stall_cnt1", stall_count, 1);

      // Branch over a hazard: flush, one shadow cycle without hazard, then RUN.
      do_reset();
      set_exe_hazard();
      branch_taken = 1'b1;
      #2;
      check("br_flush", flush, 1);
      check("br_hazard", hazard, 0);
      cyc();
      branch_taken = 1'b0;
      #2;
      check("br_shadow_state", state, 2);
      check("br_shadow_hazard", hazard, 0);
      check("br_shadow_freeze_if", freeze_if, 0);
      cyc();
      #2;
      check("br_after_state", state, 0);
      check("br_after_hazard", hazard, 1);

      // Four-cycle memory wait.
      do_reset();
      mem_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         #2;
         check($sformatf("mw_fp_c%0d", k), freeze_pipe, 1);
         check($sformatf("mw_state_c%0d", k), state, (k == 1) ? 0 : 1);
         cyc();
      end
      mem_ready = 1'b1;
      #2;
      check("mw_fp_c5", freeze_pipe, 0);
      check("mw_state_c5", state, 1);
      cyc();
      idle();
      #2;
      check("mw_state_c6", state, 0);

      // Timeout: sticky once the wait reaches WAIT_LIMIT, cleared only by reset.
      do_reset();
      mem_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         #2;
         if (k == 2) check("to_early", mem_timeout, 0);
         if (k == 5) check("to_4th_wait", mem_timeout, 1);
         cyc();
      end
      idle();
      cyc(); cyc(); cyc();
      #2;
      check("to_sticky", mem_timeout, 1);
      check("to_state_run", state, 0);
      rst = 1'b1;
      cyc();
      #2;
      check("to_cleared", mem_timeout, 0);
      rst = 1'b0;
      cyc();

      // Reset in the middle of a memory wait with stall_count=9.
      do_reset();
      set_exe_hazard();
      for (int k = 0; k < 5; k++) cyc();
      idle();
      mem_req = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      #2;
      check("rmw_stall9", stall_count, 9);
      check("rmw_in_wait", state, 1);
      rst = 1'b1;
      #1;
      check("rmw_rst_fp", freeze_pipe, 0);
      cyc();
      #2;
      check("rmw_state", state, 0);
      check("rmw_stall", stall_count, 0);
      check("rmw_freeze_if", freeze_if, 0);
      rst = 1'b0;
      idle();
      #1;
      check("rmw_release_state", state, 0);
      cyc();

      // Stall counter saturates and never wraps.
      do_reset();
      set_exe_hazard();
      for (int k = 0; k < STALL_MAX + 6; k++) cyc();
      #2;
      check("stall_sat", stall_count, STALL_MAX);
      cyc();
      #2;
      check("stall_nowrap", stall_count, STALL_MAX);

      // Randomized traffic against the reference model.
      do_reset();
      m_state = 0; m_wait = 0; m_stall = 0; m_to = 0;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(99) == 0);
         fwd_en = 1'($urandom_range(1));
         id_two_src = 1'($urandom_range(1));
         id_ignore_hazard = ($urandom_range(7) == 0);
         exe_wb_en = 1'($urandom_range(1));
         exe_mem_read = 1'($urandom_range(1));
         mem_wb_en = 1'($urandom_range(1));
         id_src1 = 4'($urandom_range(3)); id_src2 = 4'($urandom_range(3));
         exe_dest = 4'($urandom_range(3)); mem_dest = 4'($urandom_range(3));
         branch_taken = ($urandom_range(7) == 0);
         mem_req = ($urandom_range(2) == 0);
         mem_ready = ($urandom_range(3) == 0);

         e_fp = mem_req && !mem_ready;
         e_fl = branch_taken && !e_fp;
         e_hz = ref_raw() && !e_fp && !e_fl && (m_state != 2);
         e_fi = e_hz || e_fp;
         #2;
         check("rnd_hazard", hazard, rst ? 0 : e_hz);
         check("rnd_flush", flush, rst ? 0 : e_fl);
         check("rnd_freeze_pipe", freeze_pipe, rst ? 0 : e_fp);
         check("rnd_freeze_if", freeze_if, rst ? 0 : e_fi);
         check("rnd_state", state, rst ? 0 : m_state);
         check("rnd_stall", stall_count, rst ? 0 : m_stall);
         check("rnd_timeout", mem_timeout, rst ? 0 : m_to);

         if (rst) begin
            m_state = 0; m_wait = 0; m_stall = 0; m_to = 0;
         end else begin
            case (m_state)
               1:       nxt = e_fp ? 1 : (branch_taken ? 2 : 0);
               0, 2:    nxt = e_fp ? 1 : (e_fl ? 2 : 0);
               default: nxt = 0;
            endcase
            if (m_state == 1) begin
               if (m_wait < WAIT_LIMIT) m_wait++;
               if (m_wait == WAIT_LIMIT && !mem_ready) m_to = 1;
            end else if (nxt == 1) begin
               m_wait = 0;
            end
            if (e_fi && m_stall < STALL_MAX) m_stall++;
            m_state = nxt;
         end
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
